mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it accepts the address, write-data and write-strobe lines driven by the CPU core and returns read bytes one cycle later. RAM-region accesses go to an internal byte array. Accesses in the I/O region are decoded into a UART transmit FIFO, a receive handshake, a cycle counter and a program-stop flag. It sits between the CPU core and the RAM/UART side of the FPGA top level.

## Interface
Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries)

Ports (one clock; reset is asynchronous and active-high):
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; responder frozen when low
- mem_a  input  32  byte address from CPU; bits [17:0] are decoded
- mem_dout  input  8  write data from CPU
- mem_wr  input  1  1 = write, 0 = read
- mem_din  output  8  read data to CPU, valid the cycle after the read
- io_buffer_full  output  1  TX FIFO nearly full
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts byte when tx_valid && tx_ready
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  one-cycle pop pulse for the rx byte
- program_stop  output  1  sticky; set by a write to 0x30004

## Operation
- Decode: mem_a[17:16]==2'b11 selects I/O; otherwise RAM at index mem_a[RAM_ADDR_W-1:0].
- Every cycle with rdy_in high is an access: read if mem_wr=0, write if mem_wr=1.
- RAM write stores mem_dout. RAM read registers the byte to mem_din.
- I/O write 0x30000: push mem_dout into the TX FIFO.
  - Value 0x00 is ignored.
  - A push while the FIFO is full is dropped.
- I/O write 0x30004: set program_stop and push 0x00 into the TX FIFO. Both happen even though this is a zero byte.
- I/O read 0x30000:
  - If rx_valid: mem_din <= rx_data and rx_ready pulses in the same cycle.
  - Otherwise mem_din <= 0x00 and rx_ready stays low.
- I/O read 0x30004–0x30007: returns byte mem_a[1:0] of the counter snapshot, little-endian.
  - A read of 0x30004 first loads the snapshot from the live counter and returns byte 0 of the new value.
  - Reads of 0x30005–0x30007 return bytes 1–3 of the held snapshot.
- Any other I/O address: reads return 0x00; writes have no effect.
- Cycle counter: 32 bits, increments in each cycle with rdy_in high, wraps 0xFFFFFFFF->0.
- TX FIFO:
  - Head drives tx_data.
  - tx_valid = !empty.
  - Pops when tx_valid && tx_ready.
  - Pop and push in the same cycle are both performed.
  - tx pops proceed regardless of rdy_in.
- io_buffer_full = (count >= 2^TX_DEPTH_LOG2 - 2). The margin covers the CPU's one-cycle reaction latency.
- rdy_in low:
  - No RAM write, no FIFO push, no rx pop, no counter increment.
  - mem_din holds its value.

## Timing
- Read latency: exactly 1 cycle; mem_din is updated on the clock edge that samples the read.
- Write: takes effect on the sampling edge. A RAM read of the same address in the next cycle returns the new byte.
- rx_ready: asserted combinationally in the read cycle. It is only high while rdy_in && !mem_wr && addr==0x30000 && rx_valid.
- io_buffer_full and tx_valid are registered-state functions, with no combinational path from mem_* inputs.
- Reset values:
  - mem_din=0, program_stop=0, counter=0, snapshot=0.
  - FIFO empty, so tx_valid=0 and io_buffer_full=0.
  - tx_data=0; rx_ready is 0 during reset.
  - RAM contents are not reset.
- Reset asserted mid-operation: a pending push or pop is discarded and state clears immediately.
- program_stop clears only on reset.

## Configuration
- MEM_IO_CYCLE_COUNTER_EN defined: the counter and snapshot are built, and reads of 0x30004–0x30007 behave as above.
- Undefined: no counter or snapshot registers exist. Those reads return 0x00. The write-0x30004 stop behaviour is unchanged.

## Structure
- Shared package mem_io_pkg:
  - IO_BASE_SEL = 2'b11
  - ADDR_UART = 18'h30000
  - ADDR_CLK_STOP = 18'h30004
  - Byte type definition
- Sub-module byte_fifo (parameter DEPTH_LOG2):
  - Synchronous FIFO with push, pop, full, empty and count.
  - Instantiated once, for TX.

## Test plan
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only.
- Hold tx_ready=0 and write 14 non-zero bytes -> io_buffer_full=1 after the 14th push. The 17th write is dropped, and the FIFO drains in order once tx_ready=1.
- Present rx_valid=1, rx_data=0x37, read 0x30000 -> rx_ready pulse 1 cycle, mem_din=0x37. Read again with rx_valid=0 -> 0x00.
- With macro defined, run N cycles then read 0x30004..0x30007 on consecutive cycles -> bytes reassemble to the counter value at the 0x30004 read. Repeat with rdy_in held low for 5 cycles and confirm the count excludes them.
- Write 0x00 to 0x30004, then assert rst_in mid-drain -> program_stop=1 and tx gets 0x00. After reset, program_stop=0, tx_valid=0, mem_din=0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and I/O address map for the CPU memory-bus responder.
package mem_io_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0]  IO_BASE_SEL   = 2'b11;
  localparam logic [17:0] ADDR_UART     = 18'h30000;
  localparam logic [17:0] ADDR_CLK_STOP = 18'h30004;

  // Little-endian byte lane select from a 32-bit word.
  function automatic byte_t pick_byte(input logic [31:0] word, input logic [1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO; the head is presented combinationally and reads 0 while empty.
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                push,
  input  byte_t               push_data,
  input  logic                pop,
  output byte_t               head,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

  byte_t                 mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a stale write during reset is unreachable once pointers clear.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: internal RAM plus UART TX FIFO, RX handshake, stop flag and cycle counter.
// Define MEM_IO_CYCLE_COUNTER_EN to build the cycle counter and its read snapshot.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W    = 17,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  localparam logic [TX_DEPTH_LOG2:0] NEAR_FULL =
    (TX_DEPTH_LOG2 + 1)'((1 << TX_DEPTH_LOG2) - 2);

  byte_t                   ram [2**RAM_ADDR_W];
  logic [17:0]             addr;
  logic [RAM_ADDR_W-1:0]   ram_idx;
  logic                    is_io;
  logic                    io_wr;
  logic                    io_rd;
  logic                    tx_push;
  byte_t                   tx_push_data;
  logic                    tx_empty;
  logic                    tx_full;
  logic [TX_DEPTH_LOG2:0]  tx_count;
  byte_t                   cnt_byte;
  byte_t                   io_rd_byte;
  logic                    unused_hi;

  assign addr      = mem_a[17:0];
  assign ram_idx   = mem_a[RAM_ADDR_W-1:0];
  assign is_io     = (addr[17:16] == IO_BASE_SEL);
  assign io_wr     = rdy_in && mem_wr && is_io;
  assign io_rd     = rdy_in && !mem_wr && is_io;
  assign unused_hi = ^mem_a[31:18];

  // A stop write pushes a zero byte so the host sees the end of output.
  assign tx_push      = io_wr && (((addr == ADDR_UART) && (mem_dout != 8'h00)) ||
                                  (addr == ADDR_CLK_STOP));
  assign tx_push_data = (addr == ADDR_CLK_STOP) ? 8'h00 : mem_dout;

  byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign tx_valid       = !tx_empty;
  assign io_buffer_full = (tx_count >= NEAR_FULL);
  assign rx_ready       = !rst_in && io_rd && (addr == ADDR_UART) && rx_valid;

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_snap;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle_cnt  <= '0;
      cycle_snap <= '0;
    end else if (rdy_in) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (io_rd && (addr == ADDR_CLK_STOP)) cycle_snap <= cycle_cnt;
    end
  end

  // The low-byte read returns the live count so it matches the snapshot it loads.
  assign cnt_byte = (addr == ADDR_CLK_STOP) ? cycle_cnt[7:0] : pick_byte(cycle_snap, addr[1:0]);
`else
  assign cnt_byte = 8'h00;
`endif

  always_comb begin
    io_rd_byte = 8'h00;
    if (addr == ADDR_UART)
      io_rd_byte = rx_valid ? rx_data : 8'h00;
    else if (addr[17:2] == ADDR_CLK_STOP[17:2])
      io_rd_byte = cnt_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && mem_wr && !is_io) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din <= 8'h00;
    end else if (rdy_in && !mem_wr) begin
      mem_din <= is_io ? io_rd_byte : ram[ram_idx];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      program_stop <= 1'b0;
    else if (io_wr && (addr == ADDR_CLK_STOP))
      program_stop <= 1'b1;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a randomized phase against a cycle model.
module tb_mem_io_responder;
  import mem_io_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop)
  );

  int          tests = 0;
  int          fails = 0;
  byte_t       ram_m [int];
  byte_t       tx_q [$];
  byte_t       got_q [$];
  byte_t       m_din;
  bit          din_known;
  bit          m_stop;
  int unsigned m_cnt;
  int unsigned m_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    m_din     = 8'h00;
    din_known = 1'b1;
    m_stop    = 1'b0;
    m_cnt     = 0;
    m_snap    = 0;
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic tick();
    logic [17:0] a;
    bit          io;
    bit          do_push;
    bit          was_full;
    byte_t       pd;
    #1;
    a  = mem_a[17:0];
    io = (a[17:16] == 2'b11);
    chk("rx_ready", rx_ready, rdy_in && !mem_wr && (a == 18'h30000) && rx_valid);
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    do_push = 1'b0;
    pd      = 8'h00;
    if (rdy_in) begin
      if (!io) begin
        if (mem_wr) ram_m[int'(a[16:0])] = mem_dout;
        else if (ram_m.exists(int'(a[16:0]))) begin
          m_din = ram_m[int'(a[16:0])];
          din_known = 1'b1;
        end else din_known = 1'b0;
      end else if (mem_wr) begin
        if (a == 18'h30000 && mem_dout != 8'h00) begin do_push = 1'b1; pd = mem_dout; end
        if (a == 18'h30004) begin m_stop = 1'b1; do_push = 1'b1; pd = 8'h00; end
      end else begin
        din_known = 1'b1;
        if (a == 18'h30000) m_din = rx_valid ? rx_data : 8'h00;
`ifdef MEM_IO_CYCLE_COUNTER_EN
        else if (a == 18'h30004) begin m_snap = m_cnt; m_din = 8'(m_cnt); end
        else if (a[17:2] == 16'hC001) m_din = 8'(m_snap >> (8 * a[1:0]));
`endif
        else m_din = 8'h00;
      end
    end
    was_full = (tx_q.size() >= 16);
    if (tx_q.size() > 0 && tx_ready) void'(tx_q.pop_front());
    if (do_push && !was_full) tx_q.push_back(pd);
    if (rdy_in) m_cnt++;
    @(posedge clk_in);
    #1;
    if (din_known) chk("mem_din", mem_din, m_din);
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    chk("tx_data", tx_data, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    chk("io_buffer_full", io_buffer_full, tx_q.size() >= 14);
    chk("program_stop", program_stop, m_stop);
  endtask

  task automatic acc(input bit rdy, input bit wr, input logic [31:0] a, input byte_t d);
    rdy_in   = rdy;
    mem_wr   = wr;
    mem_a    = {$urandom_range(0, 16383), a[17:0]};
    mem_dout = d;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_din"}, mem_din, 8'h00);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_io_buffer_full"}, io_buffer_full, 1'b0);
    chk({tag, "_program_stop"}, program_stop, 1'b0);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_cnt;
    logic [31:0] got_cnt;
    int          n;

    rst_in = 1'b1; rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h30000; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
    #2;
    check_reset_outputs("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0; rx_valid = 1'b0;
    model_reset();

    // RAM write then read-back
    acc(1, 1, 32'h10, 8'hA5);
    acc(1, 0, 32'h10, 8'h00);
    chk("ram_readback", mem_din, 8'hA5);

    // Zero bytes are filtered out of the TX stream
    tx_ready = 1'b1;
    got_q.delete();
    acc(1, 1, 32'h30000, 8'h41);
    acc(1, 1, 32'h30000, 8'h00);
    acc(1, 1, 32'h30000, 8'h42);
    repeat (3) acc(1, 0, 32'h30008, 8'h00);
    chk("tx_seq_len", got_q.size(), 2);
    chk("tx_seq_0", got_q[0], 8'h41);
    chk("tx_seq_1", got_q[1], 8'h42);

    // Fill to near-full, overflow, then drain in order
    tx_ready = 1'b0;
    for (int i = 0; i < 14; i++) acc(1, 1, 32'h30000, byte_t'(8'h10 + i));
    chk("near_full_at_14", io_buffer_full, 1'b1);
    for (int i = 14; i < 17; i++) acc(1, 1, 32'h30000, byte_t'(8'h10 + i));
    got_q.delete();
    tx_ready = 1'b1;
    repeat (20) acc(1, 0, 32'h30008, 8'h00);
    chk("drain_len", got_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("drain_order", got_q[i], 8'h10 + i);

    // RX handshake
    rx_valid = 1'b1; rx_data = 8'h37;
    acc(1, 0, 32'h30000, 8'h00);
    chk("rx_byte", mem_din, 8'h37);
    rx_valid = 1'b0;
    acc(1, 0, 32'h30000, 8'h00);
    chk("rx_empty_byte", mem_din, 8'h00);

    // Counter snapshot readback, with and without stalled cycles
    for (int pass = 0; pass < 2; pass++) begin
      n = $urandom_range(20, 60);
      repeat (n) acc(1, 0, 32'h30008, 8'h00);
      if (pass == 1) repeat (5) acc(0, 0, 32'h30004, 8'h00);
      exp_cnt = m_cnt;
      got_cnt = '0;
      for (int b = 0; b < 4; b++) begin
        acc(1, 0, 32'h30004 + b, 8'h00);
        got_cnt[8*b +: 8] = mem_din;
      end
`ifdef MEM_IO_CYCLE_COUNTER_EN
      chk("counter_value", got_cnt, exp_cnt);
`else
      chk("counter_absent", got_cnt, 32'h0);
`endif
    end

    // Randomized mix
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      int          r;
      r        = $urandom_range(0, 9);
      tx_ready = $urandom_range(0, 1);
      rx_valid = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      ra       = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 2)) << 16);
      case (r)
        0, 1: acc($urandom_range(0, 4) != 0, 1, ra, 8'($urandom));
        2, 3: acc($urandom_range(0, 4) != 0, 0, ra, 8'h00);
        4:    acc($urandom_range(0, 4) != 0, 1, 32'h30000,
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        5:    acc($urandom_range(0, 4) != 0, 0, 32'h30000, 8'h00);
        6:    acc($urandom_range(0, 4) != 0, 0, 32'h30004 + $urandom_range(0, 3), 8'h00);
        7:    acc($urandom_range(0, 4) != 0, $urandom_range(0, 1),
                  32'h30008 + $urandom_range(0, 255), 8'($urandom));
        8:    acc(1, ($urandom_range(0, 7) == 0), 32'h30004, 8'h00);
        default: acc(1, 0, 32'h3FFFF, 8'h00);
      endcase
    end

    // Stop write, then reset asserted mid-drain
    tx_ready = 1'b1;
    repeat (20) acc(1, 0, 32'h30008, 8'h00);
    tx_ready = 1'b0;
    got_q.delete();
    acc(1, 1, 32'h30004, 8'h00);
    chk("stop_set", program_stop, 1'b1);
    acc(1, 1, 32'h30000, 8'h61);
    acc(1, 1, 32'h30000, 8'h62);
    tx_ready = 1'b1;
    acc(1, 0, 32'h30008, 8'h00);
    chk("stop_byte_sent", (got_q.size() == 1) ? {24'h0, got_q[0]} : 32'hFFFF_FFFF, 32'h0);
    rst_in = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    acc(1, 0, 32'h30008, 8'h00);
    chk("post_reset_stop", program_stop, 1'b0);
    acc(1, 0, 32'h10, 8'h00);
    chk("ram_survives_reset", mem_din, 8'hA5 === ram_m[16] ? 8'hA5 : ram_m[16]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
